// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction queue between fetch and decode: compacts 0-2
// instructions per cycle into a circular buffer and presents the oldest two.
module inst_fetch_queue #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic [31:0]             enq_inst1_i,
  input  logic [ADDR_WIDTH-1:0]   enq_addr1_i,
  input  logic                    enq_pred1_i,
  input  logic                    enq_valid1_i,
  input  logic [31:0]             enq_inst2_i,
  input  logic [ADDR_WIDTH-1:0]   enq_addr2_i,
  input  logic                    enq_pred2_i,
  input  logic                    enq_valid2_i,
  output logic                    enq_ready_o,
  output logic [31:0]             deq_inst1_o,
  output logic [ADDR_WIDTH-1:0]   deq_addr1_o,
  output logic                    deq_pred1_o,
  output logic                    deq_valid1_o,
  output logic [31:0]             deq_inst2_o,
  output logic [ADDR_WIDTH-1:0]   deq_addr2_o,
  output logic                    deq_pred2_o,
  output logic                    deq_valid2_o,
  input  logic                    deq_take1_i,
  input  logic                    deq_take2_i,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]           inst_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic                  pred_mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0] head1_c, wr_idx2_c;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] n_enq_c, n_deq_c;
  logic             ready_q, ready_d;
  logic             valid1_q, valid1_d, valid2_q, valid2_d;
  logic             enq_go_c, take1_ok_c, take2_ok_c;

  // Pointer/occupancy bookkeeping; flush overrides enqueue and dequeue.
  always_comb begin
    enq_go_c   = ready_q && !flush_i;
    take1_ok_c = deq_take1_i && (count_q != CNT_W'(0));
    take2_ok_c = take1_ok_c && deq_take2_i && (count_q >= CNT_W'(2));
    n_enq_c    = enq_go_c ? (CNT_W'(enq_valid1_i) + CNT_W'(enq_valid2_i)) : CNT_W'(0);
    n_deq_c    = CNT_W'(take1_ok_c) + CNT_W'(take2_ok_c);
    head1_c    = head_q + PTR_W'(1);
    wr_idx2_c  = enq_valid1_i ? (tail_q + PTR_W'(1)) : tail_q;

    head_d  = head_q + PTR_W'(n_deq_c);
    tail_d  = tail_q + PTR_W'(n_enq_c);
    count_d = count_q + n_enq_c - n_deq_c;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    ready_d  = (count_d <= CNT_W'(DEPTH - 2));
    valid1_d = (count_d >= CNT_W'(1));
    valid2_d = (count_d >= CNT_W'(2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      valid1_q <= valid1_d;
      valid2_q <= valid2_d;
    end
  end

  // Storage is not reset; a lone slot-2 instruction lands at tail.
  always_ff @(posedge clk) begin
    if (enq_go_c && enq_valid1_i) begin
      inst_mem[tail_q] <= enq_inst1_i;
      addr_mem[tail_q] <= enq_addr1_i;
      pred_mem[tail_q] <= enq_pred1_i;
    end
    if (enq_go_c && enq_valid2_i) begin
      inst_mem[wr_idx2_c] <= enq_inst2_i;
      addr_mem[wr_idx2_c] <= enq_addr2_i;
      pred_mem[wr_idx2_c] <= enq_pred2_i;
    end
  end

  assign enq_ready_o  = ready_q;
  assign deq_valid1_o = valid1_q;
  assign deq_valid2_o = valid2_q;
  assign deq_inst1_o  = inst_mem[head_q];
  assign deq_addr1_o  = addr_mem[head_q];
  assign deq_pred1_o  = pred_mem[head_q];
  assign deq_inst2_o  = inst_mem[head1_c];
  assign deq_addr2_o  = addr_mem[head1_c];
  assign deq_pred2_o  = pred_mem[head1_c];
  assign count_o      = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed, table-driven bench for inst_fetch_queue (DEPTH=8).
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic [31:0] enq_inst1_i, enq_addr1_i, enq_inst2_i, enq_addr2_i;
  logic        enq_pred1_i, enq_valid1_i, enq_pred2_i, enq_valid2_i;
  logic        enq_ready_o;
  logic [31:0] deq_inst1_o, deq_addr1_o, deq_inst2_o, deq_addr2_o;
  logic        deq_pred1_o, deq_valid1_o, deq_pred2_o, deq_valid2_o;
  logic        deq_take1_i, deq_take2_i;
  logic [3:0]  count_o;

  int checks = 0;
  int errors = 0;

  inst_fetch_queue #(.DEPTH(8), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .enq_inst1_i(enq_inst1_i), .enq_addr1_i(enq_addr1_i),
    .enq_pred1_i(enq_pred1_i), .enq_valid1_i(enq_valid1_i),
    .enq_inst2_i(enq_inst2_i), .enq_addr2_i(enq_addr2_i),
    .enq_pred2_i(enq_pred2_i), .enq_valid2_i(enq_valid2_i),
    .enq_ready_o(enq_ready_o),
    .deq_inst1_o(deq_inst1_o), .deq_addr1_o(deq_addr1_o),
    .deq_pred1_o(deq_pred1_o), .deq_valid1_o(deq_valid1_o),
    .deq_inst2_o(deq_inst2_o), .deq_addr2_o(deq_addr2_o),
    .deq_pred2_o(deq_pred2_o), .deq_valid2_o(deq_valid2_o),
    .deq_take1_i(deq_take1_i), .deq_take2_i(deq_take2_i),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush, v1, v2, t1, t2;
    logic [31:0] a1, a2;
    int          cnt;
    logic        rdy, dv1, dv2;
    logic [31:0] e1, e2;
  } vec_t;

  vec_t vecs[$];

  // Instruction word and prediction flag are derived from the address so a
  // single expected address also pins the expected inst/pred fields.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  function automatic logic pred_of(input logic [31:0] a);
    return a[2];
  endfunction

  function automatic vec_t mk(input logic fl, input logic v1, input logic v2,
                              input logic t1, input logic t2,
                              input logic [31:0] a1, input logic [31:0] a2,
                              input int cnt, input logic rdy,
                              input logic dv1, input logic dv2,
                              input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.flush = fl; v.v1 = v1; v.v2 = v2; v.t1 = t1; v.t2 = t2;
    v.a1 = a1; v.a2 = a2; v.cnt = cnt; v.rdy = rdy;
    v.dv1 = dv1; v.dv2 = dv2; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic v1, input logic v2,
                       input logic t1, input logic t2,
                       input logic [31:0] a1, input logic [31:0] a2);
    flush_i      = fl;
    enq_valid1_i = v1;
    enq_valid2_i = v2;
    enq_addr1_i  = a1;
    enq_addr2_i  = a2;
    enq_inst1_i  = inst_of(a1);
    enq_inst2_i  = inst_of(a2);
    enq_pred1_i  = pred_of(a1);
    enq_pred2_i  = pred_of(a2);
    deq_take1_i  = t1;
    deq_take2_i  = t2;
  endtask

  task automatic check_outputs(input string tag, input int cnt, input logic rdy,
                               input logic dv1, input logic dv2,
                               input logic [31:0] e1, input logic [31:0] e2);
    chk({tag, ".count"}, 64'(count_o), 64'(cnt));
    chk({tag, ".ready"}, 64'(enq_ready_o), 64'(rdy));
    chk({tag, ".valid1"}, 64'(deq_valid1_o), 64'(dv1));
    chk({tag, ".valid2"}, 64'(deq_valid2_o), 64'(dv2));
    if (dv1) begin
      chk({tag, ".addr1"}, 64'(deq_addr1_o), 64'(e1));
      chk({tag, ".inst1"}, 64'(deq_inst1_o), 64'(inst_of(e1)));
      chk({tag, ".pred1"}, 64'(deq_pred1_o), 64'(pred_of(e1)));
    end
    if (dv2) begin
      chk({tag, ".addr2"}, 64'(deq_addr2_o), 64'(e2));
      chk({tag, ".inst2"}, 64'(deq_inst2_o), 64'(inst_of(e2)));
      chk({tag, ".pred2"}, 64'(deq_pred2_o), 64'(pred_of(e2)));
    end
  endtask

  localparam logic [31:0] B = 32'h8000_0000;

  initial begin
    // fl v1 v2 t1 t2 a1 a2 | cnt rdy dv1 dv2 e1 e2
    vecs.push_back(mk(0,1,1,0,0, B+'h000, B+'h004, 2,1,1,1, B+'h000, B+'h004)); // basic pair
    vecs.push_back(mk(0,0,0,1,1, 0, 0,             0,1,0,0, 0, 0));
    vecs.push_back(mk(0,0,1,0,0, B+'h0F0, B+'h104, 1,1,1,0, B+'h104, 0));       // lone slot 2
    vecs.push_back(mk(0,0,0,1,0, 0, 0,             0,1,0,0, 0, 0));
    vecs.push_back(mk(0,1,1,0,0, B+'h200, B+'h204, 2,1,1,1, B+'h200, B+'h204)); // fill
    vecs.push_back(mk(0,1,1,0,0, B+'h208, B+'h20C, 4,1,1,1, B+'h200, B+'h204));
    vecs.push_back(mk(0,1,1,0,0, B+'h210, B+'h214, 6,1,1,1, B+'h200, B+'h204)); // enq straddles 7->0
    vecs.push_back(mk(0,1,1,0,0, B+'h218, B+'h21C, 8,0,1,1, B+'h200, B+'h204)); // full
    vecs.push_back(mk(0,1,1,0,0, B+'h300, B+'h304, 8,0,1,1, B+'h200, B+'h204)); // ignored
    vecs.push_back(mk(0,0,0,1,1, 0, 0,             6,1,1,1, B+'h208, B+'h20C));
    vecs.push_back(mk(0,0,0,1,1, 0, 0,             4,1,1,1, B+'h210, B+'h214)); // deq straddles 7->0
    vecs.push_back(mk(0,0,0,1,1, 0, 0,             2,1,1,1, B+'h218, B+'h21C));
    vecs.push_back(mk(0,0,0,1,0, 0, 0,             1,1,1,0, B+'h21C, 0));
    vecs.push_back(mk(0,0,0,1,0, 0, 0,             0,1,0,0, 0, 0));
    vecs.push_back(mk(0,1,1,0,0, B+'h400, B+'h404, 2,1,1,1, B+'h400, B+'h404));
    vecs.push_back(mk(0,1,1,1,1, B+'h408, B+'h40C, 2,1,1,1, B+'h408, B+'h40C));
    vecs.push_back(mk(0,1,0,1,0, B+'h410, B+'h0,   2,1,1,1, B+'h40C, B+'h410)); // head=6
    vecs.push_back(mk(0,1,1,1,1, B+'h500, B+'h504, 2,1,1,1, B+'h500, B+'h504)); // enq+deq wrap
    vecs.push_back(mk(0,1,1,0,0, B+'h600, B+'h604, 4,1,1,1, B+'h500, B+'h504));
    vecs.push_back(mk(0,1,0,0,0, B+'h608, B+'h0,   5,1,1,1, B+'h500, B+'h504));
    vecs.push_back(mk(1,1,1,1,0, B+'h6F0, B+'h6F4, 0,1,0,0, 0, 0));             // flush priority
    vecs.push_back(mk(0,1,1,0,0, B+'h700, B+'h704, 2,1,1,1, B+'h700, B+'h704));
    vecs.push_back(mk(0,1,0,0,0, B+'h708, B+'h0,   3,1,1,1, B+'h700, B+'h704));
    vecs.push_back(mk(0,0,0,0,1, 0, 0,             3,1,1,1, B+'h700, B+'h704)); // take2 alone
    vecs.push_back(mk(0,0,0,1,0, 0, 0,             2,1,1,1, B+'h704, B+'h708));
    vecs.push_back(mk(0,0,0,1,0, 0, 0,             1,1,1,0, B+'h708, 0));
    vecs.push_back(mk(0,0,0,1,1, 0, 0,             0,1,0,0, 0, 0));             // take2 on count 1
    vecs.push_back(mk(0,0,0,1,0, 0, 0,             0,1,0,0, 0, 0));             // take1 on empty
    vecs.push_back(mk(0,1,1,1,1, B+'h800, B+'h804, 2,1,1,1, B+'h800, B+'h804));

    drive(0,0,0,0,0,0,0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 0, 1'b1, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].flush, vecs[i].v1, vecs[i].v2, vecs[i].t1, vecs[i].t2,
            vecs[i].a1, vecs[i].a2);
      @(posedge clk);
      #1;
      check_outputs($sformatf("v%0d", i), vecs[i].cnt, vecs[i].rdy,
                    vecs[i].dv1, vecs[i].dv2, vecs[i].e1, vecs[i].e2);
    end

    // Asynchronous reset mid-stream: count is 2 here.
    @(negedge clk);
    drive(0,0,0,0,0,0,0);
    rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 0, 1'b1, 1'b0, 1'b0, 0, 0);
    #2;
    rst_n = 1'b1;

    // No bypass: a new pair is not visible before the capturing edge.
    @(negedge clk);
    drive(0,1,1,0,0, B+'h900, B+'h904);
    #1;
    check_outputs("no_bypass", 0, 1'b1, 1'b0, 1'b0, 0, 0);
    @(posedge clk);
    #1;
    check_outputs("after_edge", 2, 1'b1, 1'b1, 1'b1, B+'h900, B+'h904);
    @(negedge clk);
    drive(0,0,0,0,0,0,0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Dual-issue instruction queue between the IFU output stage and the ID stage.
- Accepts 0–2 fetched instructions per cycle with their addresses and predicted-branch flags, and compacts them into a circular buffer.
- Presents the oldest two entries to decode, which consumes 0–2 in order.
- Decouples AXI fetch latency from decode stalls; flushes on redirect.

Parameters:
DEPTH, 8, number of entries; power of two, at least 4
ADDR_WIDTH, 32, instruction address width (matches INST_ADDR_WIDTH)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
flush_i  input  1  discard all entries (jump/flush from control unit)
enq_inst1_i  input  32  older incoming instruction
enq_addr1_i  input  ADDR_WIDTH  address of enq_inst1_i
enq_pred1_i  input  1  predicted-branch flag for slot 1
enq_valid1_i  input  1  slot 1 valid
enq_inst2_i  input  32  younger incoming instruction
enq_addr2_i  input  ADDR_WIDTH  address of enq_inst2_i
enq_pred2_i  input  1  predicted-branch flag for slot 2
enq_valid2_i  input  1  slot 2 valid
enq_ready_o  output  1  queue can accept two entries this cycle
deq_inst1_o  output  32  head instruction
deq_addr1_o  output  ADDR_WIDTH  head address
deq_pred1_o  output  1  head predicted-branch flag
deq_valid1_o  output  1  head entry present
deq_inst2_o  output  32  head+1 instruction
deq_addr2_o  output  ADDR_WIDTH  head+1 address
deq_pred2_o  output  1  head+1 predicted-branch flag
deq_valid2_o  output  1  head+1 entry present
deq_take1_i  input  1  decode consumes head this cycle
deq_take2_i  input  1  decode also consumes head+1
count_o  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Clock and reset: single clock, clk; asynchronous active-low reset, rst_n.
- Reset values:
  - head, tail and count are 0.
  - All deq_valid outputs are 0 and enq_ready_o is 1.
  - Storage contents are don't-care; deq data outputs may show stale storage but are qualified by the valid bits.
- Storage: each entry is {inst[31:0], addr, pred}.
  - head and tail are $clog2(DEPTH)-bit pointers that wrap modulo DEPTH.
  - count is tracked separately so that full (count==DEPTH) and empty (count==0) are unambiguous.
- enq_ready_o:
  - Equals (DEPTH - count >= 2), computed from registered count only.
  - There is no combinational path from the deq_take inputs to enq_ready_o.
- Enqueue:
  - Occurs only when enq_ready_o=1; valid inputs while enq_ready_o=0 are ignored, and the upstream stage must hold them.
  - n_enq = enq_valid1_i + enq_valid2_i.
  - Compaction when only slot 2 is valid (misaligned-PC case): slot 2 is written at tail.
  - Both valid: slot 1 at tail, slot 2 at tail+1.
  - tail advances by n_enq.
- Dequeue:
  - deq_valid1_o = (count>=1) and deq_valid2_o = (count>=2); outputs are read combinationally from storage at head and head+1.
  - n_deq = take1 + (take1 & take2) for the handshake; a take on an invalid slot is ignored (take2 when count<2, take1 when count==0).
  - take2 without take1 is ignored, preserving in-order consumption.
  - head advances by n_deq.
- Simultaneous events:
  - count_next = count + n_enq - n_deq in the same cycle.
  - Enqueue and dequeue may both occur at any occupancy, including when count equals DEPTH-2 or 2.
  - Enqueued entries become visible on deq outputs no earlier than the next cycle; there is no bypass, so latency is 1 cycle minimum.
- Flush:
  - flush_i has priority over enqueue and dequeue in the same cycle.
  - Next cycle: head=tail=count=0, deq_valid outputs are 0 and enq_ready_o=1.
  - Instructions presented with flush_i are dropped.
- Reset asserted mid-operation clears the queue immediately (asynchronously), identical to the reset state.
- Wrap-around: pointer arithmetic is modulo DEPTH. An enqueue pair or dequeue pair that straddles index DEPTH-1 to 0 must keep program order.

Test Plan:
- Basic pair: reset, then enqueue {0x00000013@0x80000000, 0x00100093@0x80000004} with no takes. Next cycle: deq_valid1/2=1, deq_addr1=0x80000000, deq_addr2=0x80000004, count_o=2.
- Misaligned single: enq_valid1=0, enq_valid2=1 with addr 0x80000004 into an empty queue. Next cycle: deq_valid1=1, deq_addr1=0x80000004, deq_valid2=0, count_o=1.
- Fill/backpressure, DEPTH=8:
  - Enqueue pairs with no takes; after 3 pairs count_o=6 and enq_ready_o=1; after the 4th pair count_o=8 and enq_ready_o=0.
  - A further valid pair is ignored and count stays 8.
  - Take1+take2 for 1 cycle: count_o=6 and enq_ready_o=1.
- Simultaneous enqueue/dequeue with wrap:
  - Start with head=6 and count=2; enqueue a pair while taking 2.
  - Result: count_o=2, deq_addr1/2 are the new pair in order, and tail has wrapped to 2.
- Flush priority: count=5, and flush_i asserted together with an enqueue pair and take1. Next cycle: count_o=0, deq_valid1/2=0, enq_ready_o=1.
- Illegal takes and reset:
  - take2 alone with count=3 leaves count=3; take1+take2 with count=1 gives count=0.
  - Asserting rst_n=0 mid-stream clears deq_valid1/2 immediately, without waiting for a clk edge.
